aes_bus_regs: RTL
=================

// Module: aes_bus_regs
// PURPOSE
//  EIM-bus register front-end for an external AES-128 cipher core, successor to the fixed-key bus glue.
//  Key and plaintext are loaded a word at a time over the bus, a run is started by a CTRL write, and
//  ciphertext plus sticky status are read back. Adds a done-timeout watchdog and error bits.
//  Sits between the EIM slave decode and one aes_cipher_top instance.
// PARAMETERS
//  BUS_W    16      bus data width; legal 8/16/32; NW = 128/BUS_W words per 128-bit field
//  ADDR_W   16      bus address width
//  BASE     16'h0   block base; block hit when addr[ADDR_W-1:6] == BASE[ADDR_W-1:6]
//  KEY_RST  128'h593847fb7c86cf74a3e54bd76988a510   key register reset value
//  TIMEOUT  64      max cycles in BUSY before timeout error; >=16
// PORTS
//  clk            in   1       clock
//  rst_n          in   1       asynchronous active-low reset
//  wr             in   1       bus write strobe, 1 cycle per word
//  addr           in   ADDR_W  bus word address
//  eim_in         in   BUS_W   write data
//  eim_out        out  BUS_W   registered read data
//  core_ld        out  1       1-cycle load/start pulse to cipher core
//  core_key       out  128     key register, continuous
//  core_text_in   out  128     plaintext register, continuous
//  core_done      in   1       core result-valid strobe
//  core_text_out  in   128     core ciphertext
//  irq            out  1       only with AES_BUS_IRQ_EN
// BEHAVIOUR
//  Map (offset = addr[5:0]); word i covers bits [i*BUS_W +: BUS_W]:
//   0x00+i KEY rw | 0x10+i TEXT_IN rw | 0x20+i TEXT_OUT ro | 0x30 CTRL wo | 0x31 STATUS ro
//   i < NW; other offsets and non-hit addresses read 0, writes ignored.
//  CTRL write: bit0 START, bit1 CLEAR; reads 0. STATUS: [0] busy [1] done [2] overrun [3] timeout
//   [4] irq_pending (0 without macro); upper bits 0.
//  Reads: eim_out <= mux(addr) every cycle; 1-cycle latency, independent of wr.
//  FSM IDLE -> LOAD -> BUSY -> DONE; BUSY -> ERR on timeout.
//   IDLE/DONE + START: LOAD; done<=0. LOAD: core_ld=1 for exactly 1 cycle, -> BUSY, counter<=0.
//   BUSY: counter++; core_done -> capture core_text_out into TEXT_OUT, done<=1, -> DONE.
//   BUSY: counter==TIMEOUT-1 without core_done -> timeout<=1, -> ERR; TEXT_OUT unchanged.
//   ERR: START ignored and sets overrun; CLEAR -> IDLE.
//  busy = state in {LOAD, BUSY}. core_done outside BUSY is ignored.
//  KEY/TEXT_IN writes or START while busy: write dropped, overrun<=1.
//  CLEAR clears done/overrun/timeout/irq_pending, DONE/ERR -> IDLE; CLEAR while busy clears bits only.
//  CLEAR+START in same write: clear first, then START evaluated from resulting state.
//  core_done coincident with timeout cycle: done wins, no timeout.
//  Reset (async, any state): state IDLE, KEY=KEY_RST, TEXT_IN=0, TEXT_OUT=0, status 0, counter 0,
//   eim_out=0, core_ld=0, irq=0. Run in flight is abandoned; late core_done is ignored.
// CONFIGURATION
//  AES_BUS_IRQ_EN defined: irq port exists. irq_pending sets on BUSY->DONE or BUSY->ERR, clears on CLEAR.
//   irq = irq_pending, registered. Reset value 0.
//  Undefined: no irq port; STATUS[4] reads 0; no interrupt logic.
// TESTING
//  Reset: rst_n low mid-BUSY -> eim_out=0, core_ld=0; KEY read = KEY_RST words; STATUS=0.
//  BUS_W=16: write TEXT_IN 0x10..0x17 = 0x0000..0x0007 -> core_text_in = 128'h0007_0006_..._0000.
//  Run: START; core_done 10 cycles after core_ld, text_out=128'h3925841d02dc09fbdc118597196a0b32
//   -> core_ld single pulse; STATUS=0x2; reads 0x20..0x27 return 0x0b32,0x196a,...,0x3925.
//  Overrun: KEY write in BUSY -> KEY unchanged, STATUS=0x5; START in BUSY -> second core_ld absent.
//  Timeout: START, no core_done -> STATUS=0x8 after TIMEOUT cycles in BUSY; START -> STATUS=0xC;
//   CLEAR -> 0x0; START -> LOAD.
//  IRQ (macro on): completion -> irq=1 and STATUS[4]=1; CLEAR+START same write -> irq=0, new run.

Source files
------------

// File: rtl/aes_bus_regs.sv
// aes_bus_regs -- EIM-bus register front-end for an external AES-128 cipher core.
//
// The key and plaintext are loaded one bus word at a time. A CTRL write starts a
// run, and the ciphertext and sticky status bits are read back over the bus. A
// watchdog counts cycles in BUSY and flags a timeout if the core never answers.
//
// Register map (offset = addr[5:0]; word i holds bits [i*BUS_W +: BUS_W], i < NW):
//   0x00+i KEY rw | 0x10+i TEXT_IN rw | 0x20+i TEXT_OUT ro | 0x30 CTRL wo | 0x31 STATUS ro
//   CTRL:   [0] START, [1] CLEAR
//   STATUS: [0] busy [1] done [2] overrun [3] timeout [4] irq_pending
//
// Optional feature macro: AES_BUS_IRQ_EN adds the irq output and the irq_pending
// status bit. When the macro is not defined, STATUS[4] reads 0.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   wr/addr/eim_in bus write strobe, word address, write data
//   eim_out        registered read data (1-cycle latency)
//   core_ld        1-cycle load/start pulse to the cipher core
//   core_key       key register (128 bit), driven continuously
//   core_text_in   plaintext register (128 bit), driven continuously
//   core_done      core result-valid strobe
//   core_text_out  core ciphertext
//   irq            interrupt (present only with AES_BUS_IRQ_EN)

module aes_bus_regs #(
    parameter int unsigned       BUS_W   = 16,
    parameter int unsigned       ADDR_W  = 16,
    parameter logic [ADDR_W-1:0] BASE    = '0,
    parameter logic [127:0]      KEY_RST = 128'h593847fb7c86cf74a3e54bd76988a510,
    parameter int unsigned       TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [BUS_W-1:0]  eim_in,
    output logic [BUS_W-1:0]  eim_out,
    output logic              core_ld,
    output logic [127:0]      core_key,
    output logic [127:0]      core_text_in,
    input  logic              core_done,
    input  logic [127:0]      core_text_out
`ifdef AES_BUS_IRQ_EN
    ,
    output logic              irq
`endif
);

    localparam int unsigned NW    = 128 / BUS_W;
    localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_BUSY,
        S_DONE,
        S_ERR
    } state_e;

    state_e             state_q, state_d;
    logic [127:0]       key_q, key_d;
    logic [127:0]       text_in_q, text_in_d;
    logic [127:0]       text_out_q, text_out_d;
    logic               done_q, done_d;
    logic               overrun_q, overrun_d;
    logic               timeout_q, timeout_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BUS_W-1:0]   eim_out_q, eim_out_d;
`ifdef AES_BUS_IRQ_EN
    logic               irq_pending_q, irq_pending_d;
`endif

    logic       hit;
    logic [5:0] off;
    logic [3:0] idx;
    logic       in_range;
    logic       wr_key;
    logic       wr_text;
    logic       wr_ctrl;
    logic       start;
    logic       clear;
    logic       busy;
    state_e     state_eff;

    assign hit      = (addr[ADDR_W-1:6] == BASE[ADDR_W-1:6]);
    assign off      = addr[5:0];
    assign idx      = addr[3:0];
    assign in_range = (32'(idx) < NW);
    assign wr_key   = wr && hit && (off[5:4] == 2'b00) && in_range;
    assign wr_text  = wr && hit && (off[5:4] == 2'b01) && in_range;
    assign wr_ctrl  = wr && hit && (off == 6'h30);
    assign start    = wr_ctrl && eim_in[0];
    assign clear    = wr_ctrl && eim_in[1];
    assign busy     = (state_q == S_LOAD) || (state_q == S_BUSY);

    // CLEAR takes effect first. START is then decoded from the state that CLEAR
    // leaves behind, so CLEAR+START in one write restarts a finished or errored run.
    assign state_eff = (clear && (state_q == S_DONE || state_q == S_ERR)) ? S_IDLE : state_q;

    always_comb begin
        state_d    = state_eff;
        key_d      = key_q;
        text_in_d  = text_in_q;
        text_out_d = text_out_q;
        done_d     = done_q;
        overrun_d  = overrun_q;
        timeout_d  = timeout_q;
        cnt_d      = cnt_q;
`ifdef AES_BUS_IRQ_EN
        irq_pending_d = irq_pending_q;
`endif

        if (clear) begin
            done_d    = 1'b0;
            overrun_d = 1'b0;
            timeout_d = 1'b0;
`ifdef AES_BUS_IRQ_EN
            irq_pending_d = 1'b0;
`endif
        end

        // Operand writes land only when no run is in flight; otherwise flag overrun.
        if (wr_key || wr_text) begin
            if (busy) begin
                overrun_d = 1'b1;
            end else begin
                for (int unsigned i = 0; i < NW; i++) begin
                    if (idx == i[3:0]) begin
                        if (wr_key) key_d[i*BUS_W +: BUS_W] = eim_in;
                        else        text_in_d[i*BUS_W +: BUS_W] = eim_in;
                    end
                end
            end
        end

        case (state_eff)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_LOAD;
                    done_d  = 1'b0;
                end
            end
            S_LOAD: begin
                if (start) overrun_d = 1'b1;
                state_d = S_BUSY;
                cnt_d   = '0;
            end
            S_BUSY: begin
                if (start) overrun_d = 1'b1;
                cnt_d = cnt_q + CNT_W'(1);
                // A result arriving on the watchdog's last cycle still counts as success.
                if (core_done) begin
                    text_out_d = core_text_out;
                    done_d     = 1'b1;
                    state_d    = S_DONE;
`ifdef AES_BUS_IRQ_EN
                    irq_pending_d = 1'b1;
`endif
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = S_ERR;
`ifdef AES_BUS_IRQ_EN
                    irq_pending_d = 1'b1;
`endif
                end
            end
            S_ERR: begin
                if (start) overrun_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Read mux: registered every cycle from the current address, whether or not wr is high.
    always_comb begin
        eim_out_d = '0;
        if (hit) begin
            case (off[5:4])
                2'b00, 2'b01, 2'b10: begin
                    for (int unsigned i = 0; i < NW; i++) begin
                        if (in_range && idx == i[3:0]) begin
                            case (off[5:4])
                                2'b00:   eim_out_d = key_q[i*BUS_W +: BUS_W];
                                2'b01:   eim_out_d = text_in_q[i*BUS_W +: BUS_W];
                                default: eim_out_d = text_out_q[i*BUS_W +: BUS_W];
                            endcase
                        end
                    end
                end
                default: begin
                    if (off == 6'h31) begin
                        eim_out_d[0] = busy;
                        eim_out_d[1] = done_q;
                        eim_out_d[2] = overrun_q;
                        eim_out_d[3] = timeout_q;
`ifdef AES_BUS_IRQ_EN
                        eim_out_d[4] = irq_pending_q;
`endif
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            key_q      <= KEY_RST;
            text_in_q  <= '0;
            text_out_q <= '0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
            timeout_q  <= 1'b0;
            cnt_q      <= '0;
            eim_out_q  <= '0;
`ifdef AES_BUS_IRQ_EN
            irq_pending_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            text_in_q  <= text_in_d;
            text_out_q <= text_out_d;
            done_q     <= done_d;
            overrun_q  <= overrun_d;
            timeout_q  <= timeout_d;
            cnt_q      <= cnt_d;
            eim_out_q  <= eim_out_d;
`ifdef AES_BUS_IRQ_EN
            irq_pending_q <= irq_pending_d;
`endif
        end
    end

    assign eim_out      = eim_out_q;
    assign core_ld      = (state_q == S_LOAD);
    assign core_key     = key_q;
    assign core_text_in = text_in_q;
`ifdef AES_BUS_IRQ_EN
    assign irq          = irq_pending_q;
`endif

endmodule
